// File: rtl/dram_write_sink.sv
// Write sink feeding a DRAM port: an address FIFO and a write-data FIFO are paired
// (one address + two 128-bit beats) and issued as a single 256-bit burst per handshake.
//
// state | meaning
// IDLE  | waiting for one address and at least two data beats
// LOAD  | pop one address and two beats into the output registers
// ISSUE | present the burst on the memory port until mem_ready
module dram_write_sink #(
  parameter int AF_DEPTH  = 4,
  parameter int WDF_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [30:0]  af_addr_din,
  input  logic [2:0]   af_cmd_din,
  input  logic         af_wr_en,
  output logic         af_full,
  input  logic [127:0] wdf_din,
  input  logic [15:0]  wdf_mask_din,
  input  logic         wdf_wr_en,
  output logic         wdf_full,
  output logic         mem_valid,
  input  logic         mem_ready,
  output logic [30:0]  mem_addr,
  output logic [255:0] mem_data,
  output logic [31:0]  mem_mask,
  output logic         err_overflow,
  output logic         err_cmd
);

  localparam int AP_W = $clog2(AF_DEPTH);
  localparam int AC_W = AP_W + 1;
  localparam int WP_W = $clog2(WDF_DEPTH);
  localparam int WC_W = WP_W + 1;
  localparam logic [AC_W-1:0] AF_FULL_CNT  = AC_W'(AF_DEPTH);
  localparam logic [WC_W-1:0] WDF_FULL_CNT = WC_W'(WDF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [30:0]  r_af_mem  [AF_DEPTH];
  logic [143:0] r_wdf_mem [WDF_DEPTH];

  logic [AP_W-1:0] r_af_wr_ptr;
  logic [AP_W-1:0] r_af_rd_ptr;
  logic [AC_W-1:0] r_af_cnt;
  logic [WP_W-1:0] r_wdf_wr_ptr;
  logic [WP_W-1:0] r_wdf_rd_ptr;
  logic [WC_W-1:0] r_wdf_cnt;

  logic [30:0]  r_mem_addr;
  logic [255:0] r_mem_data;
  logic [31:0]  r_mem_mask;
  logic         r_err_overflow;
  logic         r_err_cmd;

  logic            w_af_push;
  logic            w_wdf_push;
  logic            w_pop;
  logic            w_burst_avail;
  logic [WP_W-1:0] w_wdf_rd_ptr1;
  logic [143:0]    w_beat0;
  logic [143:0]    w_beat1;

  assign af_full  = (r_af_cnt == AF_FULL_CNT);
  assign wdf_full = (r_wdf_cnt == WDF_FULL_CNT);

  // Illegal commands never enter the FIFO, so they can't consume a slot.
  assign w_af_push  = af_wr_en && !af_full && (af_cmd_din == 3'b000);
  assign w_wdf_push = wdf_wr_en && !wdf_full;
  assign w_pop      = (r_state == S_LOAD);

  assign w_burst_avail = (r_af_cnt != '0) && (r_wdf_cnt >= WC_W'(2));

  assign w_wdf_rd_ptr1 = r_wdf_rd_ptr + WP_W'(1);
  assign w_beat0       = r_wdf_mem[r_wdf_rd_ptr];
  assign w_beat1       = r_wdf_mem[w_wdf_rd_ptr1];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_burst_avail) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_ISSUE;
      S_ISSUE: if (mem_ready) w_state_nxt = w_burst_avail ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Storage arrays carry no reset; validity is tracked by the counts.
  always_ff @(posedge clk) begin
    if (w_af_push)  r_af_mem[r_af_wr_ptr]   <= af_addr_din;
    if (w_wdf_push) r_wdf_mem[r_wdf_wr_ptr] <= {wdf_mask_din, wdf_din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_af_wr_ptr <= '0;
      r_af_rd_ptr <= '0;
      r_af_cnt    <= '0;
    end else begin
      if (w_af_push) r_af_wr_ptr <= r_af_wr_ptr + AP_W'(1);
      if (w_pop)     r_af_rd_ptr <= r_af_rd_ptr + AP_W'(1);
      unique case ({w_af_push, w_pop})
        2'b10:   r_af_cnt <= r_af_cnt + AC_W'(1);
        2'b01:   r_af_cnt <= r_af_cnt - AC_W'(1);
        default: r_af_cnt <= r_af_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdf_wr_ptr <= '0;
      r_wdf_rd_ptr <= '0;
      r_wdf_cnt    <= '0;
    end else begin
      if (w_wdf_push) r_wdf_wr_ptr <= r_wdf_wr_ptr + WP_W'(1);
      if (w_pop)      r_wdf_rd_ptr <= r_wdf_rd_ptr + WP_W'(2);
      unique case ({w_wdf_push, w_pop})
        2'b10:   r_wdf_cnt <= r_wdf_cnt + WC_W'(1);
        2'b01:   r_wdf_cnt <= r_wdf_cnt - WC_W'(2);
        2'b11:   r_wdf_cnt <= r_wdf_cnt - WC_W'(1);
        default: r_wdf_cnt <= r_wdf_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_mask <= '0;
    end else if (w_pop) begin
      r_mem_addr <= r_af_mem[r_af_rd_ptr];
      r_mem_data <= {w_beat1[127:0], w_beat0[127:0]};
      r_mem_mask <= {w_beat1[143:128], w_beat0[143:128]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_overflow <= 1'b0;
      r_err_cmd      <= 1'b0;
    end else begin
      if ((af_wr_en && af_full) || (wdf_wr_en && wdf_full)) r_err_overflow <= 1'b1;
      if (af_wr_en && (af_cmd_din != 3'b000))               r_err_cmd      <= 1'b1;
    end
  end

  assign mem_valid    = (r_state == S_ISSUE);
  assign mem_addr     = r_mem_addr;
  assign mem_data     = r_mem_data;
  assign mem_mask     = r_mem_mask;
  assign err_overflow = r_err_overflow;
  assign err_cmd      = r_err_cmd;

endmodule
